mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Arbitrates between the two stages with data-side priority and a starvation guard for fetch.
- Runs each transaction through a request/acknowledge handshake to the memory.
- Drives per-stage stall signals to the hazard control unit while a stage's access is outstanding.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, maximum consecutive data grants while I_Req is pending before fetch is forced; legal range 1..15.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- I_Req  in  1  fetch requests an instruction read; held with I_Addr stable until I_Valid.
- I_Addr  in  ADDR_W  fetch address.
- I_Valid  out  1  one-cycle pulse: I_RData valid, transaction done.
- I_RData  out  DATA_W  instruction word.
- D_Req  in  1  memory stage requests an access; held with D_* stable until D_Valid.
- D_W_En  in  1  1 = store, 0 = load.
- D_Addr  in  ADDR_W  data address.
- D_WData  in  DATA_W  store data.
- D_Byte_En  in  DATA_W/8  store byte lanes.
- D_Valid  out  1  one-cycle pulse: data transaction done; D_RData valid for loads.
- D_RData  out  DATA_W  load word (raw; the memory stage extends it).
- MEM_Req  out  1  transaction outstanding to memory.
- MEM_W_En  out  1  write strobe qualifier.
- MEM_Addr  out  ADDR_W  memory address.
- MEM_WData  out  DATA_W  memory write data.
- MEM_Byte_En  out  DATA_W/8  memory byte lanes.
- MEM_RData  in  DATA_W  memory read data, valid with MEM_Ack.
- MEM_Ack  in  1  one-cycle completion from memory; any latency >= 1 cycle after MEM_Req rises.
- Stall_F  out  1  I_Req & ~I_Valid.
- Stall_M  out  1  D_Req & ~D_Valid.

Behaviour:
- Reset (RST low, asynchronous):
  - State = IDLE and starve count = 0.
  - All MEM_* outputs, I_Valid, D_Valid, I_RData and D_RData are 0.
  - Takes effect immediately, including mid-transaction. A pending MEM_Ack after reset release is ignored.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE: requests are sampled only in this state.
  - If D_Req=1 and (I_Req=0 or starve count < STARVE_LIMIT): go to BUSY_D. If I_Req=1, increment starve count (saturating at STARVE_LIMIT); otherwise clear it.
  - Else if I_Req=1: go to BUSY_I and clear starve count.
  - Else: stay in IDLE.
  - On entry to a BUSY state, register the winner's fields into MEM_*:
    - Fetch: MEM_W_En=0, MEM_Byte_En all ones, MEM_WData=0.
    - Data: the D_* values.
    - MEM_Req=1.
- BUSY_x:
  - MEM_Req and MEM_* are held constant until MEM_Ack=1.
  - On MEM_Ack: capture MEM_RData into x_RData (D_RData gets 0 for stores), drop MEM_Req, go to DONE_x.
- DONE_x:
  - x_Valid=1 for exactly this cycle; next state IDLE.
  - The requester may change or drop its request on the next edge. Its old request is never re-sampled because IDLE follows DONE.
- Timing:
  - With an Ack latency of L, transaction occupancy is L+2 cycles from the IDLE sample to the Valid pulse.
  - Back-to-back minimum spacing between Valid pulses is L+3.
- Boundary conditions:
  - MEM_Ack in IDLE or DONE: ignored.
  - Requester drops its request while BUSY: the transaction still completes and Valid still pulses. This is a protocol violation but must be benign.
  - Simultaneous requests with starve count = STARVE_LIMIT: fetch wins and the count clears.
  - x_RData holds its value between transactions, with no X propagation.

Test Plan:
- Reset: RST low mid-BUSY_D with MEM_Ack arriving during reset → MEM_Req=0, D_Valid=0, D_RData=0; the first cycle after release is IDLE.
- Single fetch: I_Req=1, I_Addr=0x100, memory acks 2 cycles later with 0x00500093 → MEM_Addr=0x100, MEM_W_En=0, MEM_Byte_En=0xF; I_Valid pulses 1 cycle with I_RData=0x00500093; Stall_F high until that pulse.
- Store: D_Req=1, D_W_En=1, D_Addr=0x2004, D_WData=0xDEADBEEF, D_Byte_En=0x3 → matching MEM_* fields held until Ack; D_Valid pulses with D_RData=0.
- Contention: I_Req and D_Req both held high continuously, STARVE_LIMIT=4, Ack latency 1 → grant sequence D,D,D,D,I,D,D,D,D,I.
- Spurious Ack: MEM_Ack pulsed while IDLE with no requests → no Valid pulse, no state change; the next real transaction is unaffected.
- Minimum spacing: fetch with Ack latency 1 repeated back-to-back → consecutive I_Valid pulses exactly 4 cycles apart.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data, memory-port and stall signals around the unified-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_valid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_w_en;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_byte_en;
  logic                  d_valid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_w_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_byte_en;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  logic                  stall_f;
  logic                  stall_m;

  modport slave (
    input  i_req, i_addr,
    output i_valid, i_rdata,
    input  d_req, d_w_en, d_addr, d_wdata, d_byte_en,
    output d_valid, d_rdata,
    output mem_req, mem_w_en, mem_addr, mem_wdata, mem_byte_en,
    input  mem_rdata, mem_ack,
    output stall_f, stall_m
  );

  modport master (
    output i_req, i_addr,
    input  i_valid, i_rdata,
    output d_req, d_w_en, d_addr, d_wdata, d_byte_en,
    input  d_valid, d_rdata,
    input  mem_req, mem_w_en, mem_addr, mem_wdata, mem_byte_en,
    output mem_rdata, mem_ack,
    input  stall_f, stall_m
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory: data-side priority with a
// starvation guard that forces a fetch grant after STARVE_LIMIT consecutive data wins.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);
  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          starve_cnt_reg, starve_cnt_next;
  logic                load_i, load_d, capture;

  logic                mem_req_reg;
  logic                mem_w_en_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [BE_W-1:0]     mem_byte_en_reg;
  logic [DATA_W-1:0]   i_rdata_reg;
  logic [DATA_W-1:0]   d_rdata_reg;
  logic                i_valid, d_valid;

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    load_i          = 1'b0;
    load_d          = 1'b0;
    capture         = 1'b0;
    case (state_reg)
      IDLE: begin
        // A data win with fetch waiting only happens below the limit, so +1 never overshoots.
        if (bus.d_req && (!bus.i_req || (starve_cnt_reg < STARVE_MAX))) begin
          state_next      = BUSY_D;
          load_d          = 1'b1;
          starve_cnt_next = bus.i_req ? (starve_cnt_reg + 4'd1) : 4'd0;
        end else if (bus.i_req) begin
          state_next      = BUSY_I;
          load_i          = 1'b1;
          starve_cnt_next = 4'd0;
        end
      end
      BUSY_I: begin
        if (bus.mem_ack) begin
          capture    = 1'b1;
          state_next = DONE_I;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          capture    = 1'b1;
          state_next = DONE_D;
        end
      end
      DONE_I:  state_next = IDLE;
      DONE_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      starve_cnt_reg  <= 4'd0;
      mem_req_reg     <= 1'b0;
      mem_w_en_reg    <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_byte_en_reg <= '0;
      i_rdata_reg     <= '0;
      d_rdata_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      mem_req_reg    <= (state_next == BUSY_I) || (state_next == BUSY_D);
      if (load_i) begin
        mem_w_en_reg    <= 1'b0;
        mem_addr_reg    <= bus.i_addr;
        mem_wdata_reg   <= '0;
        mem_byte_en_reg <= '1;
      end
      if (load_d) begin
        mem_w_en_reg    <= bus.d_w_en;
        mem_addr_reg    <= bus.d_addr;
        mem_wdata_reg   <= bus.d_wdata;
        mem_byte_en_reg <= bus.d_byte_en;
      end
      if (capture) begin
        if (state_reg == BUSY_I) begin
          i_rdata_reg <= bus.mem_rdata;
        end else begin
          // Stores return no data; keep the load path clean.
          d_rdata_reg <= mem_w_en_reg ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  assign i_valid         = (state_reg == DONE_I);
  assign d_valid         = (state_reg == DONE_D);

  assign bus.i_valid     = i_valid;
  assign bus.d_valid     = d_valid;
  assign bus.i_rdata     = i_rdata_reg;
  assign bus.d_rdata     = d_rdata_reg;
  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_w_en    = mem_w_en_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.mem_byte_en = mem_byte_en_reg;
  assign bus.stall_f     = bus.i_req & ~i_valid;
  assign bus.stall_m     = bus.d_req & ~d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store, contention, spurious ack,
// back-to-back spacing and asynchronous reset during a data transaction.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits for the grant, acks after lat cycles, returns positioned in the DONE cycle.
  task automatic run_txn(input int lat, input logic [31:0] rd);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      tick();
      seen = bus.mem_req;
    end
    check1("mem_req_rise", seen, 1'b1);
    repeat (lat) tick();
    check1("mem_req_held", bus.mem_req, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    $display("txn cyc=%0d addr=0x%08h we=%0b i_valid=%0b d_valid=%0b i_rdata=0x%08h d_rdata=0x%08h",
             cyc, bus.mem_addr, bus.mem_w_en, bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata);
  endtask

  initial begin
    logic [9:0] exp_d;
    int         c_prev;
    exp_d = 10'b01111_01111;

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_w_en = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_byte_en = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;

    // Reset state
    repeat (3) tick();
    check1 ("rst_mem_req", bus.mem_req, 1'b0);
    check32("rst_mem_addr", bus.mem_addr, 32'h0);
    check32("rst_mem_be", {28'h0, bus.mem_byte_en}, 32'h0);
    check1 ("rst_i_valid", bus.i_valid, 1'b0);
    check1 ("rst_d_valid", bus.d_valid, 1'b0);
    check32("rst_i_rdata", bus.i_rdata, 32'h0);
    check32("rst_d_rdata", bus.d_rdata, 32'h0);

    // Single fetch, ack latency 2
    rst_n = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    tick();
    check1 ("f_mem_req", bus.mem_req, 1'b1);
    check32("f_mem_addr", bus.mem_addr, 32'h100);
    check1 ("f_mem_we", bus.mem_w_en, 1'b0);
    check32("f_mem_be", {28'h0, bus.mem_byte_en}, 32'hF);
    check32("f_mem_wdata", bus.mem_wdata, 32'h0);
    check1 ("f_stall_busy", bus.stall_f, 1'b1);
    tick();
    check1 ("f_no_early_valid", bus.i_valid, 1'b0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    $display("txn cyc=%0d fetch i_valid=%0b i_rdata=0x%08h", cyc, bus.i_valid, bus.i_rdata);
    check1 ("f_valid", bus.i_valid, 1'b1);
    check32("f_rdata", bus.i_rdata, 32'h0050_0093);
    check1 ("f_stall_done", bus.stall_f, 1'b0);
    check1 ("f_mem_req_drop", bus.mem_req, 1'b0);
    bus.i_req = 1'b0;
    tick();
    check1 ("f_valid_one_cycle", bus.i_valid, 1'b0);
    check32("f_rdata_hold", bus.i_rdata, 32'h0050_0093);

    // Store, ack latency 3
    bus.d_req = 1'b1; bus.d_w_en = 1'b1; bus.d_addr = 32'h2004;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_byte_en = 4'h3;
    tick();
    check1 ("s_stall_m", bus.stall_m, 1'b1);
    repeat (3) tick();
    check1 ("s_mem_req", bus.mem_req, 1'b1);
    check1 ("s_mem_we", bus.mem_w_en, 1'b1);
    check32("s_mem_addr", bus.mem_addr, 32'h2004);
    check32("s_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check32("s_mem_be", {28'h0, bus.mem_byte_en}, 32'h3);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    $display("txn cyc=%0d store d_valid=%0b d_rdata=0x%08h", cyc, bus.d_valid, bus.d_rdata);
    check1 ("s_valid", bus.d_valid, 1'b1);
    check32("s_rdata_zero", bus.d_rdata, 32'h0);
    check1 ("s_stall_done", bus.stall_m, 1'b0);

    // Contention: both held, latency 1, grants D,D,D,D,I,D,D,D,D,I
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_w_en = 1'b0; bus.d_addr = 32'h3000;
    for (int k = 0; k < 10; k++) begin
      run_txn(1, 32'hA000_0000 + 32'(k));
      check1("c_grant_d", bus.d_valid, exp_d[k]);
      check1("c_grant_i", bus.i_valid, ~exp_d[k]);
      check1("c_stall_f", bus.stall_f, exp_d[k]);
      if (exp_d[k]) check32("c_d_rdata", bus.d_rdata, 32'hA000_0000 + 32'(k));
      else          check32("c_i_rdata", bus.i_rdata, 32'hA000_0000 + 32'(k));
    end

    // Spurious ack while idle
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0055;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    check1 ("sp_mem_req", bus.mem_req, 1'b0);
    tick();
    check1 ("sp_i_valid", bus.i_valid, 1'b0);
    check1 ("sp_d_valid", bus.d_valid, 1'b0);
    check32("sp_i_rdata", bus.i_rdata, 32'hA000_0009);
    check32("sp_d_rdata", bus.d_rdata, 32'hA000_0008);
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    run_txn(1, 32'h0000_0013);
    check1 ("sp_next_valid", bus.i_valid, 1'b1);
    check32("sp_next_rdata", bus.i_rdata, 32'h0000_0013);
    check32("sp_next_addr", bus.mem_addr, 32'h200);

    // Back-to-back fetches: Valid pulses 4 cycles apart with latency 1
    c_prev = cyc;
    for (int k = 0; k < 2; k++) begin
      run_txn(1, 32'h0000_1000 + 32'(k));
      check1 ("bb_valid", bus.i_valid, 1'b1);
      check32("bb_spacing", cyc - c_prev, 32'd4);
      c_prev = cyc;
    end

    // Asynchronous reset in the middle of a data load, ack arriving during reset
    bus.i_req = 1'b0;
    tick();
    bus.d_req = 1'b1; bus.d_w_en = 1'b0; bus.d_addr = 32'h3008;
    tick();
    check1 ("r_busy", bus.mem_req, 1'b1);
    tick();
    rst_n = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    check1 ("r_async_mem_req", bus.mem_req, 1'b0);
    check1 ("r_async_d_valid", bus.d_valid, 1'b0);
    check32("r_async_d_rdata", bus.d_rdata, 32'h0);
    check32("r_async_mem_addr", bus.mem_addr, 32'h0);
    tick();
    check1 ("r_hold_d_valid", bus.d_valid, 1'b0);
    bus.d_req = 1'b0;
    rst_n = 1'b1;
    tick();
    check1 ("r_rel_mem_req", bus.mem_req, 1'b0);
    check1 ("r_rel_d_valid", bus.d_valid, 1'b0);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    check1 ("r_post_d_valid", bus.d_valid, 1'b0);
    check1 ("r_post_i_valid", bus.i_valid, 1'b0);
    check32("r_post_d_rdata", bus.d_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
